// File: rtl/display_word_parser_pkg.sv
// Shared constants, nibble codes and FSM state type for the display word parser.
// Optional remainder field parsing is enabled with REMAINDER_PARSE_EN.
package display_word_parser_pkg;

    localparam int NIBBLES = 8;
    localparam int VAL_W   = 21;
    localparam int ACC_W   = 24;
    localparam int WORD_W  = 4 * NIBBLES;

    localparam logic [3:0] DIGIT_R     = 4'hA;
    localparam logic [3:0] DIGIT_MINUS = 4'hE;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Largest magnitude representable without producing -2^20
    localparam int MAG_MAX = 1048575;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SIGN,
        ST_DONE
    } state_t;

    function automatic logic is_digit(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/display_word_parser_if.sv
// Request/result bundle between the entry memory side and the parser.
// Carries the remainder result fields when REMAINDER_PARSE_EN is defined.
interface display_word_parser_if;
    import display_word_parser_pkg::*;

    // start is sampled only while the parser is idle and not pulsing done;
    // display_word is captured on that same edge. done is a one-cycle pulse,
    // and value/parse_error hold from that pulse until the next one.
    logic              start;
    logic [WORD_W-1:0] display_word;
    logic              busy;
    logic              done;
    logic [VAL_W-1:0]  value;
    logic              parse_error;
    state_t            fsm_state;
`ifdef REMAINDER_PARSE_EN
    logic [VAL_W-1:0]  remainder_value;
    logic              has_remainder;
`endif

    modport master (
        output start, display_word,
        input  busy, done, value, parse_error, fsm_state
`ifdef REMAINDER_PARSE_EN
        , input remainder_value, has_remainder
`endif
    );

    modport slave (
        input  start, display_word,
        output busy, done, value, parse_error, fsm_state
`ifdef REMAINDER_PARSE_EN
        , output remainder_value, has_remainder
`endif
    );

endinterface

// File: rtl/display_word_parser_mul10_add.sv
// Combinational decimal accumulate step: acc*10 + digit, flagging results above MAG_MAX.
module mul10_add
    import display_word_parser_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam logic [ACC_W+3:0] MAX_WIDE = (ACC_W + 4)'(MAG_MAX);

    logic [ACC_W+3:0] acc_wide;
    logic [ACC_W+3:0] sum_wide;

    // Four spare bits keep the x10 product exact so the range test is honest
    assign acc_wide = {4'b0000, acc_in};
    assign sum_wide = (acc_wide << 3) + (acc_wide << 1) + {{ACC_W{1'b0}}, digit};
    assign acc_out  = sum_wide[ACC_W-1:0];
    assign overflow = sum_wide > MAX_WIDE;

endmodule

// File: rtl/display_word_parser.sv
// Converts an 8-nibble display word into a signed 21-bit operand, one nibble per clock.
// Build option REMAINDER_PARSE_EN adds a remainder field after an 'r' nibble.
module display_word_parser
    import display_word_parser_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    display_word_parser_if.slave bus
);

    localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

    state_t            state;
    state_t            state_next;
    logic              accept;

    logic [2:0]        cnt;
    logic [WORD_W-1:0] shreg;
    logic [ACC_W-1:0]  acc;
    logic              neg;
    logic              seen_digit;
    logic              err;
    logic [VAL_W-1:0]  res;

    logic              busy_q;
    logic              done_q;
    logic [VAL_W-1:0]  value_q;
    logic              perr_q;

    logic [3:0]        nib;
    logic [ACC_W-1:0]  acc_mul;
    logic              acc_ovf;
    logic [ACC_W-1:0]  acc_n;
    logic              neg_n;
    logic              seen_n;
    logic              err_n;
    logic              sign_err;
    logic [VAL_W-1:0]  mag;
    logic [VAL_W-1:0]  signed_val;

`ifdef REMAINDER_PARSE_EN
    logic [ACC_W-1:0]  rem_acc;
    logic              in_rem;
    logic              rem_seen;
    logic [ACC_W-1:0]  rem_mul;
    logic              rem_ovf;
    logic [ACC_W-1:0]  rem_acc_n;
    logic              in_rem_n;
    logic              rem_seen_n;
    logic [VAL_W-1:0]  rem_q;
    logic              has_rem_q;
`endif

    assign nib = shreg[WORD_W-1 -: 4];

    mul10_add u_mul_quot (
        .acc_in   (acc),
        .digit    (nib),
        .acc_out  (acc_mul),
        .overflow (acc_ovf)
    );

`ifdef REMAINDER_PARSE_EN
    mul10_add u_mul_rem (
        .acc_in   (rem_acc),
        .digit    (nib),
        .acc_out  (rem_mul),
        .overflow (rem_ovf)
    );
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The done cycle already shows IDLE, so a start there is held off one cycle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    accept     = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt == LAST_NIB) begin
                    state_next = ST_SIGN;
                end
            end
            ST_SIGN: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Classify the current top nibble against the flags gathered so far
    always_comb begin
        acc_n  = acc;
        neg_n  = neg;
        seen_n = seen_digit;
        err_n  = err;
`ifdef REMAINDER_PARSE_EN
        rem_acc_n  = rem_acc;
        in_rem_n   = in_rem;
        rem_seen_n = rem_seen;
`endif
        if (is_digit(nib)) begin
`ifdef REMAINDER_PARSE_EN
            if (in_rem) begin
                rem_acc_n  = rem_mul;
                rem_seen_n = 1'b1;
                if (rem_ovf) begin
                    err_n = 1'b1;
                end
            end else
`endif
            begin
                acc_n  = acc_mul;
                seen_n = 1'b1;
                if (acc_ovf) begin
                    err_n = 1'b1;
                end
            end
        end else if (nib == DIGIT_BLANK) begin
            if (seen_digit || neg) begin
                err_n = 1'b1;
            end
        end else if (nib == DIGIT_MINUS) begin
            if (seen_digit || neg) begin
                err_n = 1'b1;
            end else begin
                neg_n = 1'b1;
            end
        end
`ifdef REMAINDER_PARSE_EN
        else if (nib == DIGIT_R) begin
            if (seen_digit && !in_rem) begin
                in_rem_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
`endif
        else begin
            err_n = 1'b1;
        end
    end

    always_comb begin
        sign_err = err | (neg & ~seen_digit);
`ifdef REMAINDER_PARSE_EN
        sign_err = sign_err | (in_rem & ~rem_seen);
`endif
        mag        = acc[VAL_W-1:0];
        signed_val = neg ? (~mag + 1'b1) : mag;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            shreg      <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            seen_digit <= 1'b0;
            err        <= 1'b0;
            res        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            value_q    <= '0;
            perr_q     <= 1'b0;
`ifdef REMAINDER_PARSE_EN
            rem_acc    <= '0;
            in_rem     <= 1'b0;
            rem_seen   <= 1'b0;
            rem_q      <= '0;
            has_rem_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg      <= bus.display_word;
                        cnt        <= '0;
                        acc        <= '0;
                        neg        <= 1'b0;
                        seen_digit <= 1'b0;
                        err        <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef REMAINDER_PARSE_EN
                        rem_acc    <= '0;
                        in_rem     <= 1'b0;
                        rem_seen   <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    shreg      <= {shreg[WORD_W-5:0], 4'h0};
                    cnt        <= cnt + 3'd1;
                    acc        <= acc_n;
                    neg        <= neg_n;
                    seen_digit <= seen_n;
                    err        <= err_n;
`ifdef REMAINDER_PARSE_EN
                    rem_acc    <= rem_acc_n;
                    in_rem     <= in_rem_n;
                    rem_seen   <= rem_seen_n;
`endif
                end
                ST_SIGN: begin
                    res <= signed_val;
                    err <= sign_err;
                end
                ST_DONE: begin
                    value_q <= err ? '0 : res;
                    perr_q  <= err;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
`ifdef REMAINDER_PARSE_EN
                    rem_q     <= err ? '0 : rem_acc[VAL_W-1:0];
                    has_rem_q <= in_rem & ~err;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.value       = value_q;
    assign bus.parse_error = perr_q;
    assign bus.fsm_state   = state;
`ifdef REMAINDER_PARSE_EN
    assign bus.remainder_value = rem_q;
    assign bus.has_remainder   = has_rem_q;
`endif

endmodule

// File: tb/tb_display_word_parser.sv
// Directed and randomized checks of display_word_parser against a token-level parse model.
module tb_display_word_parser;
    import display_word_parser_pkg::*;

    localparam int EXP_W = 2 * VAL_W + 2;

    logic clock;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    display_word_parser_if bus ();

    display_word_parser dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    // Token view: blanks*, optional minus, digits, [r digits], nothing else.
    function automatic void ref_parse(input logic [31:0] w, output logic err,
                                      output logic [VAL_W-1:0] val,
                                      output logic has_r, output logic [VAL_W-1:0] rem);
        int     nibs[8];
        int     p;
        int     qd;
        int     rd;
        bit     neg;
        bit     saw_r;
        longint q;
        longint r;
        for (int i = 0; i < 8; i++) nibs[i] = int'(w[31-4*i -: 4]);
        p = 0; qd = 0; rd = 0; neg = 0; saw_r = 0; q = 0; r = 0; err = 1'b0;
        while (p < 8 && nibs[p] == 15) p++;
        if (p < 8 && nibs[p] == 14) begin
            neg = 1; p++;
        end
        while (p < 8 && nibs[p] <= 9) begin
            q = q * 10 + nibs[p]; qd++; p++;
        end
`ifdef REMAINDER_PARSE_EN
        if (p < 8 && nibs[p] == 10 && qd > 0) begin
            saw_r = 1; p++;
            while (p < 8 && nibs[p] <= 9) begin
                r = r * 10 + nibs[p]; rd++; p++;
            end
            if (rd == 0) err = 1'b1;
        end
`endif
        if (p < 8) err = 1'b1;
        if (neg && qd == 0) err = 1'b1;
        if (q > MAG_MAX || r > MAG_MAX) err = 1'b1;
        val   = err ? '0 : (neg ? VAL_W'(-q) : VAL_W'(q));
        has_r = saw_r && !err;
        rem   = err ? '0 : VAL_W'(r);
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        int nd;
        int k;
        w  = '1;
        nd = $urandom_range(0, 8);
        for (int i = 0; i < nd; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
        if (nd < 8 && $urandom_range(0, 1) == 1) w[4*nd +: 4] = DIGIT_MINUS;
        if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 7);
            w[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [31:0] w);
        logic e;
        logic h;
        logic [VAL_W-1:0] v;
        logic [VAL_W-1:0] rv;
        ref_parse(w, e, v, h, rv);
        exp_q.push_back({h, rv, e, v});
    endtask

    task automatic check_result(input string tag);
        logic [EXP_W-1:0] ex;
        ex = exp_q.pop_front();
        check({tag, ".value"}, 32'(bus.value), 32'(ex[VAL_W-1:0]));
        check({tag, ".perr"},  32'(bus.parse_error), 32'(ex[VAL_W]));
`ifdef REMAINDER_PARSE_EN
        check({tag, ".rem"},   32'(bus.remainder_value), 32'(ex[2*VAL_W:VAL_W+1]));
        check({tag, ".has_r"}, 32'(bus.has_remainder), 32'(ex[EXP_W-1]));
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic run_parse(input logic [31:0] w, input string tag);
        int lat;
        if (bus.done) begin
            @(posedge clock); #1;
        end
        bus.display_word = w;
        bus.start        = 1'b1;
        push_expected(w);
        @(posedge clock); #1;
        bus.start        = 1'b0;
        bus.display_word = $urandom();
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'd10);
        check_result(tag);
        @(posedge clock); #1;
        check({tag, ".pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        int dones;
        resetn           = 1'b0;
        bus.start        = 1'b0;
        bus.display_word = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy",  32'(bus.busy), 32'd0);
        check("rst.done",  32'(bus.done), 32'd0);
        check("rst.value", 32'(bus.value), 32'd0);
        check("rst.perr",  32'(bus.parse_error), 32'd0);
        check("rst.state", 32'(bus.fsm_state), 32'(ST_IDLE));
        resetn = 1'b1;
        @(posedge clock); #1;

        run_parse(32'hFFFF0123, "pos123");
        check("pos123.abs", 32'(bus.value), 32'd123);
        run_parse(32'hFFFE0045, "neg45");
        check("neg45.abs", 32'(bus.value), 32'h1FFFD3);
        run_parse(32'hF1048576, "ovf");
        check("ovf.abs", 32'(bus.parse_error), 32'd1);
        run_parse(32'hF1048575, "max");
        check("max.abs", 32'(bus.value), 32'd1048575);
        run_parse(32'hFE999999, "negbig");
        run_parse(32'hFF12F345, "midblank");
        check("midblank.abs", 32'(bus.parse_error), 32'd1);
        run_parse(32'hFFFFFFFE, "loneminus");
        check("loneminus.abs", 32'(bus.parse_error), 32'd1);
        run_parse(32'hFFFFFFFF, "allblank");
        run_parse(32'hFFFFFB12, "illegal");
        run_parse(32'hFEE00012, "twominus");
        run_parse(32'hFFF17A03, "rword");
`ifdef REMAINDER_PARSE_EN
        check("rword.abs", 32'(bus.remainder_value), 32'd3);
        run_parse(32'hFFFF12AF, "rblank");
        run_parse(32'hFF1A2A30, "tworr");
`else
        check("rword.abs", 32'(bus.parse_error), 32'd1);
`endif

        // reset in the middle of a scan clears outputs at once
        run_parse(32'hFFFF0777, "prev");
        bus.display_word = 32'hFFFF0555;
        bus.start        = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst.busy",  32'(bus.busy), 32'd0);
        check("midrst.done",  32'(bus.done), 32'd0);
        check("midrst.value", 32'(bus.value), 32'd0);
        check("midrst.state", 32'(bus.fsm_state), 32'(ST_IDLE));
        @(posedge clock); #1;
        resetn = 1'b1;
        dones  = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clock); #1;
            if (bus.done) dones++;
        end
        check("midrst.nodone", 32'(dones), 32'd0);

        // start pulses while busy are dropped
        bus.display_word = 32'hFFFF0042;
        bus.start        = 1'b1;
        push_expected(32'hFFFF0042);
        @(posedge clock); #1;
        bus.display_word = 32'hFFFF0099;
        dones = 0;
        for (int c = 0; c < 14; c++) begin
            bus.start = (c >= 1 && c <= 6);
            @(posedge clock); #1;
            if (bus.done) begin
                dones++;
                check_result("busystart");
            end
        end
        check("busystart.count", 32'(dones), 32'd1);

        // start raised on the done cycle is taken one cycle later
        bus.display_word = 32'hFFFFF321;
        bus.start        = 1'b1;
        push_expected(32'hFFFFF321);
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_done(lat);
        check_result("donestart.a");
        bus.display_word = 32'hFFFE0007;
        bus.start        = 1'b1;
        push_expected(32'hFFFE0007);
        @(posedge clock); #1;
        check("donestart.held", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("donestart.take", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("donestart.lat", 32'(lat), 32'd10);
        check_result("donestart.b");

        for (int n = 0; n < 40; n++) begin
            run_parse(gen_word(), "rand");
        end

        check("sb.empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_word_parser.md
Name: display_word_parser

Overview:
- Inverse of the result formatter: converts a 32-bit display word (8 BCD/code nibbles) back into a 21-bit two's-complement operand.
- Sits between display/entry memory and the ALU operand registers; used to reload stored results and keypad-composed entries.
- Sequential: one nibble per clock, MSB nibble first, start/done handshake.

Parameters:
- NIBBLES, 8, nibbles scanned per word
- VAL_W, 21, output value width (signed)
- ACC_W, 24, internal magnitude accumulator width

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request parse; sampled only in IDLE
- display_word  in  32  nibble-coded word; captured on accepted start
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse, results valid
- value  out  21  signed parsed result, held until next done
- parse_error  out  1  valid with done, held until next done

Behaviour:
- Nibble codes: 0x0-0x9 digit, 0xA 'r', 0xE minus, 0xF blank; 0xB-0xD illegal.
- Word layout: leading blanks (high nibbles), optional single minus, digits MSD to LSD ending at nibble [3:0].
- Reset (resetn low, any time, including mid-parse): state IDLE; busy, done, parse_error = 0; value = 0; internal accumulator and flags cleared.
- FSM states: IDLE, SCAN, SIGN, DONE.
- IDLE: on start=1, capture display_word into shift register, clear acc/flags, busy=1, go SCAN.
- SCAN: 8 cycles; each cycle examine nibble [31:28], then shift word left 4.
  - blank before first digit, no minus seen: skip.
  - minus before first digit, first minus: set neg.
  - digit: acc = acc*10 + d (acc<<3 + acc<<1 + d); set seen_digit.
  - blank or minus after a digit, second minus, blank after minus, 0xA, 0xB-0xD: set sticky err.
  - acc > 1048575 (2^20-1) at any step: set err (sticky); acc may keep updating, result discarded.
- SIGN: value_next = neg ? -acc : acc, truncated to 21 bits; minus with no digit → err.
- DONE: register value (0 if err) and parse_error=err; done=1 for exactly this cycle; busy=0 on the same edge done rises; return IDLE next edge.
- Latency: start accepted at edge E0; done high in cycle after E10 (SCAN E1-E8, SIGN E9, DONE E10).
- All-blank word: value 0, parse_error 0.
- Range: -1048575 .. +1048575; -1048576 not produced.
- start while busy: ignored, no queueing. start asserted on done cycle: ignored (accepted next cycle in IDLE).
- display_word changes during parse: no effect (captured copy used).

Optional Feature:
- Macro REMAINDER_PARSE_EN.
- Defined: adds ports remainder_value out 21 (unsigned magnitude) and has_remainder out 1, both reset 0. 0xA after at least one digit ends the quotient field; following digits accumulate into a second accumulator, same overflow rule. 'r' with no following digit, or a second 'r' → err. has_remainder=1 with done when 'r' parsed without error; remainder_value 0 on error.
- Undefined: ports absent; 0xA is an error nibble.

Decomposition:
- Shared package: nibble code constants (DIGIT_R=4'hA, DIGIT_MINUS=4'hE, DIGIT_BLANK=4'hF), MAG_MAX=1048575, FSM state enum, VAL_W.
- Sub-module mul10_add: combinational acc*10+digit with overflow flag; instantiated once, twice with REMAINDER_PARSE_EN.

Test Plan:
- 32'hFFFF0123 + start → done 10 cycles later, value=123, parse_error=0.
- 32'hFFFE0045 (minus, 0,0,4,5) → value=-45 (21'h1FFFD3), error 0.
- 32'hF1048576 → parse_error=1, value=0; 32'hFF1048575 style max 32'hF1048575 → value=1048575.
- 32'hFF12F345 (blank mid-digits) and 32'hFFFFFFFE (lone minus) → parse_error=1, value=0; 32'hFFFFFFFF → value=0, error 0.
- Start, then resetn low at SCAN cycle 4 → busy/done/value 0 immediately; start pulses during busy ignored (exactly one done per accepted start).
- REMAINDER_PARSE_EN: 32'hFFF17A3 style 32'hFFF17A03 → value=17, remainder_value=3, has_remainder=1; undefined → same word gives parse_error=1.
